// File: rtl/bp_pkg.sv
// Shared types and constants for the branch resolve unit.
//   PC_W        : program counter width
//   INSTR_BYTES : sequential PC increment
//   bru_state_e : resolve FSM states
//   track_entry_t : one tracking-pipe entry {valid, pc, pred}
package bp_pkg;

   localparam int unsigned PC_W        = 64;
   localparam int unsigned INSTR_BYTES = 4;

   typedef enum logic {
      StRun   = 1'b0,
      StDrain = 1'b1
   } bru_state_e;

   typedef struct packed {
      logic            valid;
      logic [PC_W-1:0] pc;
      logic [PC_W-1:0] pred;  // 0 means no prediction
   } track_entry_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bus between the pipeline and the branch resolve unit.
//   en                       : pipeline advance
//   fetch_valid/pc, predicted_pc : fetch-side PC and its BTB prediction
//   ex_*                     : resolving instruction in EX
//   flush, redirect_pc       : mispredict recovery
//   btb_*                    : BTB update write
//   branch_count, mispredict_count : saturating statistics
// Modports: master drives the pipeline side, slave is the resolve unit.
interface branch_resolve_unit_if #(
   parameter int unsigned CNT_W = 32
);
   logic                     en;
   logic                     fetch_valid;
   logic [bp_pkg::PC_W-1:0]  fetch_pc;
   logic [bp_pkg::PC_W-1:0]  predicted_pc;
   logic                     ex_valid;
   logic [bp_pkg::PC_W-1:0]  ex_pc;
   logic                     ex_is_branch;
   logic                     ex_is_jump;
   logic                     ex_taken;
   logic [bp_pkg::PC_W-1:0]  ex_target;
   logic                     flush;
   logic [bp_pkg::PC_W-1:0]  redirect_pc;
   logic [bp_pkg::PC_W-1:0]  btb_prev_pc;
   logic [bp_pkg::PC_W-1:0]  btb_branch_pc;
   logic [bp_pkg::PC_W-1:0]  btb_jump_pc;
   logic                     btb_was_taken;
   logic                     btb_jumped;
   logic [CNT_W-1:0]         branch_count;
   logic [CNT_W-1:0]         mispredict_count;

   modport master (
      output en, fetch_valid, fetch_pc, predicted_pc,
      output ex_valid, ex_pc, ex_is_branch, ex_is_jump, ex_taken, ex_target,
      input  flush, redirect_pc, btb_prev_pc, btb_branch_pc, btb_jump_pc,
      input  btb_was_taken, btb_jumped, branch_count, mispredict_count
   );

   modport slave (
      input  en, fetch_valid, fetch_pc, predicted_pc,
      input  ex_valid, ex_pc, ex_is_branch, ex_is_jump, ex_taken, ex_target,
      output flush, redirect_pc, btb_prev_pc, btb_branch_pc, btb_jump_pc,
      output btb_was_taken, btb_jumped, branch_count, mispredict_count
   );

endinterface

// File: rtl/pred_track_pipe.sv
// Shift register carrying fetched PCs and their predictions down to EX.
//   clk, arst_n : clock, synchronous active-low reset
//   en_i        : shift enable
//   inv_i       : clear every valid bit (applied after the shift)
//   entry_i     : new fetch-side entry
//   last_o      : EX-aligned entry
module pred_track_pipe
   import bp_pkg::*;
#(
   parameter int unsigned PIPE_DEPTH = 2
) (
   input  logic         clk,
   input  logic         arst_n,
   input  logic         en_i,
   input  logic         inv_i,
   input  track_entry_t entry_i,
   output track_entry_t last_o
);

   track_entry_t stage_q [PIPE_DEPTH];
   track_entry_t stage_d [PIPE_DEPTH];

   always_comb begin
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
         stage_d[i] = stage_q[i];
      end
      if (en_i) begin
         stage_d[0] = entry_i;
         for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
         end
      end
      // Invalidate wins over the incoming entry: it is wrong-path
      if (inv_i) begin
         for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
            stage_d[i].valid = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign last_o = stage_q[PIPE_DEPTH-1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Compares the BTB prediction carried down to EX with the resolved outcome,
// raises flush/redirect on mispredict, emits the BTB update write and keeps
// saturating statistics. After a mispredict, DRAIN_CYCLES en-cycles of
// wrong-path resolutions are ignored.
//   clk, arst_n : clock, synchronous active-low reset
//   bus_io      : slave side of branch_resolve_unit_if
module branch_resolve_unit
   import bp_pkg::*;
#(
   parameter int unsigned PIPE_DEPTH   = 2,
   parameter int unsigned DRAIN_CYCLES = 2,
   parameter int unsigned CNT_W        = 32
) (
   input logic                  clk,
   input logic                  arst_n,
   branch_resolve_unit_if.slave bus_io
);

   localparam int unsigned DcW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

   bru_state_e       state_q, state_d;
   logic [DcW-1:0]   drain_q, drain_d;
   track_entry_t     fetch_entry, ex_entry;

   logic             resolve, is_jump, is_branch, take, pred_hit, mispredict;
   logic [PC_W-1:0]  seq_pc, actual_next, pred_next;

   logic             flush_q, was_taken_q, jumped_q;
   logic [PC_W-1:0]  redirect_q, prev_pc_q, branch_pc_q, jump_pc_q;
   logic [CNT_W-1:0] br_cnt_q, misp_cnt_q;

   assign fetch_entry = '{valid: bus_io.fetch_valid, pc: bus_io.fetch_pc,
                          pred: bus_io.predicted_pc};

   pred_track_pipe #(
      .PIPE_DEPTH(PIPE_DEPTH)
   ) u_pipe (
      .clk     (clk),
      .arst_n  (arst_n),
      .en_i    (bus_io.en),
      .inv_i   (mispredict),
      .entry_i (fetch_entry),
      .last_o  (ex_entry)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state_q <= StRun;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      unique case (state_q)
         StRun: begin
            if (mispredict && (DRAIN_CYCLES != 0)) begin
               state_d = StDrain;
               drain_d = DcW'(DRAIN_CYCLES - 1);
            end
         end
         StDrain: begin
            if (bus_io.en) begin
               if (drain_q == '0) state_d = StRun;
               else               drain_d = drain_q - DcW'(1);
            end
         end
         default: state_d = StRun;
      endcase
   end

   // FSM outputs: resolution only happens in RUN
   always_comb begin
      resolve     = bus_io.en & bus_io.ex_valid & (state_q == StRun);
      is_jump     = bus_io.ex_is_jump;
      is_branch   = bus_io.ex_is_branch & ~bus_io.ex_is_jump;  // jump wins
      take        = is_jump | (is_branch & bus_io.ex_taken);
      seq_pc      = bus_io.ex_pc + PC_W'(INSTR_BYTES);
      actual_next = take ? bus_io.ex_target : seq_pc;
      // An invalid or PC-mismatched entry counts as no prediction
      pred_hit    = ex_entry.valid & (ex_entry.pc == bus_io.ex_pc) & (ex_entry.pred != '0);
      pred_next   = pred_hit ? ex_entry.pred : seq_pc;
      mispredict  = resolve & (actual_next != pred_next);
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         flush_q     <= 1'b0;
         was_taken_q <= 1'b0;
         jumped_q    <= 1'b0;
         redirect_q  <= '0;
         prev_pc_q   <= '0;
         branch_pc_q <= '0;
         jump_pc_q   <= '0;
         br_cnt_q    <= '0;
         misp_cnt_q  <= '0;
      end else begin
         flush_q     <= mispredict;
         was_taken_q <= resolve & is_branch & bus_io.ex_taken;
         jumped_q    <= resolve & is_jump;
         if (mispredict) redirect_q <= actual_next;
         if (resolve & take) prev_pc_q <= bus_io.ex_pc;
         if (resolve & is_branch & bus_io.ex_taken) branch_pc_q <= bus_io.ex_target;
         if (resolve & is_jump) jump_pc_q <= bus_io.ex_target;
         if (resolve & (is_branch | is_jump) & ~&br_cnt_q) br_cnt_q <= br_cnt_q + CNT_W'(1);
         if (mispredict & ~&misp_cnt_q) misp_cnt_q <= misp_cnt_q + CNT_W'(1);
      end
   end

   assign bus_io.flush            = flush_q;
   assign bus_io.redirect_pc      = redirect_q;
   assign bus_io.btb_prev_pc      = prev_pc_q;
   assign bus_io.btb_branch_pc    = branch_pc_q;
   assign bus_io.btb_jump_pc      = jump_pc_q;
   assign bus_io.btb_was_taken    = was_taken_q;
   assign bus_io.btb_jumped       = jumped_q;
   assign bus_io.branch_count     = br_cnt_q;
   assign bus_io.mispredict_count = misp_cnt_q;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Closes the branch-prediction loop at the execute end of the pipeline.
- Carries each fetched PC and its branch_target_buffer prediction down to EX and compares the prediction with the resolved outcome.
- On a mispredict, raises a flush and a redirect PC.
- Generates the update write (prev_pc / branch_pc / jump_pc / was_taken / jumped) that the branch_target_buffer consumes, plus saturating statistics counters.

Parameters:
- PIPE_DEPTH, 2, number of en-qualified cycles between fetch presentation and EX resolution (>=1).
- DRAIN_CYCLES, 2, en-qualified cycles of wrong-path resolutions ignored after a redirect.
- CNT_W, 32, width of statistics counters.

Ports:
- clk  in  1  rising-edge clock
- arst_n  in  1  reset, synchronous, active-low
- en  in  1  pipeline advance; nothing shifts, resolves or counts when 0
- fetch_valid  in  1  fetch_pc is a real instruction this cycle
- fetch_pc  in  64  PC presented to the BTB this cycle
- predicted_pc  in  64  BTB prediction for fetch_pc; 0 = no prediction (fall-through)
- ex_valid  in  1  an instruction is resolving in EX
- ex_pc  in  64  PC of the resolving instruction
- ex_is_branch  in  1  conditional branch
- ex_is_jump  in  1  unconditional jump; never set together with ex_is_branch
- ex_taken  in  1  branch outcome (ignored unless ex_is_branch)
- ex_target  in  64  resolved target of branch/jump
- flush  out  1  one-cycle pulse: squash younger stages
- redirect_pc  out  64  correct next PC; valid while flush=1
- btb_prev_pc  out  64  update PC to the BTB
- btb_branch_pc  out  64  taken-branch target to the BTB
- btb_jump_pc  out  64  jump target to the BTB
- btb_was_taken  out  1  write branch entry (one-cycle pulse)
- btb_jumped  out  1  write jump entry (one-cycle pulse)
- branch_count  out  CNT_W  resolved branches and jumps
- mispredict_count  out  CNT_W  mispredicts

Behaviour:
- Reset (arst_n=0 at posedge):
  - All outputs go to 0.
  - Tracking pipe is invalidated, FSM enters RUN, counters are cleared.
  - Reset mid-drain or mid-pulse aborts it; no pending flush or update survives.
- Tracking pipe: PIPE_DEPTH stages of {valid, pc, pred}.
  - On en, stage0 <= {fetch_valid, fetch_pc, predicted_pc} and the other stages shift.
  - The last stage is the EX-aligned entry E.
- Resolution occurs in a cycle with en=1, ex_valid=1, FSM=RUN.
  - actual_next = (ex_is_jump | (ex_is_branch & ex_taken)) ? ex_target : ex_pc+4. Arithmetic is 64-bit modulo (wraps at 2^64).
  - pred_next = (E.valid & E.pc==ex_pc & E.pred!=0) ? E.pred : ex_pc+4. An invalid or PC-mismatched E counts as no prediction.
  - mispredict = (actual_next != pred_next).
- Outputs registered at the resolution posedge (visible the next cycle, 1-cycle latency), asserted for exactly one cycle:
  - On mispredict: flush=1, redirect_pc=actual_next.
  - On a taken branch: btb_was_taken=1, btb_prev_pc=ex_pc, btb_branch_pc=ex_target.
  - On a jump: btb_jumped=1, btb_prev_pc=ex_pc, btb_jump_pc=ex_target.
  - A not-taken branch produces no BTB write.
  - btb_*_pc hold their last value when no pulse is active.
- Counters: branch_count += 1 per resolved branch or jump; mispredict_count += 1 per mispredict. Both saturate at all-ones, no wrap.
- FSM:
  - RUN -> DRAIN on mispredict; the tracking pipe is invalidated in the same edge.
  - DRAIN: an en-qualified down-counter loads DRAIN_CYCLES-1. While in DRAIN:
    - ex_valid resolutions are ignored: no flush, no BTB write, no count.
    - Fetch entries still shift in.
  - DRAIN -> RUN when the counter is 0 and en=1.
  - If DRAIN_CYCLES=0, no drain: return to RUN immediately.
- en=0: all state holds; pulse outputs drop to 0 after one cycle regardless of en.
- Simultaneous ex_is_branch and ex_is_jump is illegal; the jump takes priority.

Decomposition:
- Shared package (bp_pkg):
  - PC_W=64 and INSTR_BYTES=4.
  - FSM state enum {RUN, DRAIN}.
  - Tracking entry struct {valid, pc, pred}.
- One natural sub-module: pred_track_pipe, a parameterised PIPE_DEPTH shift register of entries with en and synchronous invalidate.

Test Plan:
- Reset: hold arst_n=0 for 2 cycles mid-drain -> all outputs 0, counters 0; first resolution afterwards behaves as RUN.
- Correct taken prediction: fetch 0x100 with pred 0x200; after 2 en cycles EX 0x100 branch taken to 0x200 -> flush=0, btb_was_taken pulse with prev=0x100, branch=0x200, branch_count=1, mispredict_count=0.
- Missing prediction: fetch 0x104 with pred 0; EX jump to 0x400 -> next cycle flush=1, redirect_pc=0x400, btb_jumped=1, jump_pc=0x400; the next 2 en-qualified ex_valid resolutions produce no flush and no count.
- Wrong taken prediction: pred 0x300 for 0x108; EX not taken -> flush=1, redirect_pc=0x10C, no BTB write, mispredict_count=1.
- Stall: en=0 for 5 cycles around a resolution -> pipe frozen, no pulses; resolution happens on the first en=1 cycle.
- Wrap/saturation: ex_pc=0xFFFF_FFFF_FFFF_FFFC not taken with stale pred -> redirect_pc=0. Forcing counters near all-ones (CNT_W=4) -> counters stick at 0xF.
